dcache1_wb_queue: RTL and testbench

DCACHE1_WB_QUEUE -- requirements
Module: dcache1_wb_queue

---
 rtl/dcache1_wb_queue_pkg.sv | 6 +
 rtl/dcache1_wbq_match.sv | 19 +
 rtl/dcache1_wb_queue.sv | 88 ++++++++
 tb/tb_dcache1_wb_queue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dcache1_wb_queue_pkg.sv
// dcache1_wb_queue_pkg: shared writeback-queue defaults and flush FSM encoding
package dcache1_wb_queue_pkg;
  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_AW = 37;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2} wbq_state_e;
endpackage

// File: rtl/dcache1_wbq_match.sv
// dcache1_wbq_match: DEPTH-way address compare of two probes (a, b) against valid entries
module dcache1_wbq_match
  import dcache1_wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW = WBQ_AW
) (
  input  logic [AW-1:0]    ent [DEPTH],
  input  logic [DEPTH-1:0] vld,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  output logic [DEPTH-1:0] hit_a,
  output logic [DEPTH-1:0] hit_b
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit_a[i] = vld[i] & (ent[i] == addr_a);
    assign hit_b[i] = vld[i] & (ent[i] == addr_b);
  end
endmodule

// File: rtl/dcache1_wb_queue.sv
// dcache1_wb_queue: coalescing writeback FIFO (ins_* from tag stage, out_* to L2, chk_* hazard probe, flush_*/ovf_err status)
module dcache1_wb_queue
  import dcache1_wb_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW = WBQ_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ins_en,
  input  logic [AW-1:0]            ins_addr,
  output logic                     ins_stall,
  output logic                     out_valid,
  output logic [AW-1:0]            out_addr,
  input  logic                     out_ready,
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_hit,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     ovf_err,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d, hit_ins, hit_chk;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, full, push, pop;
  wbq_state_e       state_q, state_d;
  dcache1_wbq_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .ent    (mem_q),
    .vld    (vld_q),
    .addr_a (ins_addr),
    .addr_b (chk_addr),
    .hit_a  (hit_ins),
    .hit_b  (hit_chk)
  );
  assign full       = count_q == CW'(DEPTH);
  assign ins_stall  = full | (state_q != RUN);
  assign out_valid  = vld_q[head_q];
  assign out_addr   = mem_q[head_q];
  assign chk_hit    = |hit_chk;
  assign flush_done = state_q == DONE;
  assign ovf_err    = ovf_q;
  assign count      = count_q;
  assign pop        = out_valid & out_ready;
  assign push       = ins_en & ~ins_stall & ~|hit_ins;
  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      mem_d[tail_q] = ins_addr;
      tail_d        = tail_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q | (ins_en & full);
    state_d = state_q == RUN   ? (flush_req ? FLUSH : RUN) :
              state_q == FLUSH ? (count_q == '0 ? DONE : FLUSH) : RUN;
  end
  always_ff @(negedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= RUN;
    end else begin
      mem_q   <= mem_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_dcache1_wb_queue.sv
// tb_dcache1_wb_queue: scoreboard bench for the coalescing writeback queue
module tb_dcache1_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW = 37;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_en = 1'b0;
  logic [AW-1:0] ins_addr = '0;
  logic          ins_stall, out_valid, chk_hit, flush_done, ovf_err;
  logic [AW-1:0] out_addr;
  logic          out_ready = 1'b0;
  logic [AW-1:0] chk_addr = '0;
  logic          flush_req = 1'b0;
  logic [2:0]    count;
  int            n_cmp = 0;
  int            n_err = 0;
  int            pulses = 0;
  int            n_pop = 0;
  int            seen_1c0 = 0;
  int            p0;
  logic [AW-1:0] sb [$];
  int            ms = 0;
  logic          movf = 1'b0;
  logic          full, stall, coal, hc;
  always #5 clk = ~clk;
  dcache1_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_en     (ins_en),
    .ins_addr   (ins_addr),
    .ins_stall  (ins_stall),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_ready  (out_ready),
    .chk_addr   (chk_addr),
    .chk_hit    (chk_hit),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .ovf_err    (ovf_err),
    .count      (count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      ms   = 0;
      movf = 1'b0;
    end else begin
      full  = sb.size() == DEPTH;
      stall = full || ms != 0;
      coal  = 1'b0;
      hc    = 1'b0;
      foreach (sb[i]) begin
        coal |= sb[i] == ins_addr;
        hc   |= sb[i] == chk_addr;
      end
      chk("count", 64'(count), 64'(sb.size()));
      chk("ins_stall", 64'(ins_stall), 64'(stall));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("chk_hit", 64'(chk_hit), 64'(hc));
      chk("flush_done", 64'(flush_done), 64'(ms == 2));
      chk("ovf_err", 64'(ovf_err), 64'(movf));
      if (sb.size() != 0) chk("out_addr", 64'(out_addr), 64'(sb[0]));
      if (flush_done) pulses++;
      if (out_valid && out_ready) n_pop++;
      if (out_valid && out_addr == 37'h1C0) seen_1c0++;
      ms = ms == 0 ? (flush_req ? 1 : 0) : ms == 1 ? (sb.size() == 0 ? 2 : 1) : 0;
      if (ins_en && full) movf = 1'b1;
      if (sb.size() != 0 && out_ready) void'(sb.pop_front());
      if (ins_en && !stall && !coal) sb.push_back(ins_addr);
    end
  end
  task automatic cyc(input logic ie, input logic [AW-1:0] ia, input logic ordy, input logic fr);
    ins_en    = ie;
    ins_addr  = ia;
    out_ready = ordy;
    flush_req = fr;
    @(negedge clk);
    #1;
  endtask
  task automatic do_rst();
    rst = 1'b1;
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    rst = 1'b0;
  endtask
  initial begin
    do_rst();
    chk("rst_count", 64'(count), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_addr", 64'(out_addr), 0);
    chk("rst_chk_hit", 64'(chk_hit), 0);
    chk("rst_ins_stall", 64'(ins_stall), 0);
    chk("rst_flush_done", 64'(flush_done), 0);
    chk("rst_ovf_err", 64'(ovf_err), 0);
    cyc(1, 37'h100, 0, 0);
    cyc(1, 37'h140, 0, 0);
    cyc(1, 37'h180, 0, 0);
    chk_addr = 37'h140;
    ins_en   = 1'b0;
    #1;
    chk("t1_count", 64'(count), 3);
    chk("t1_out_addr", 64'(out_addr), 64'h100);
    chk("t1_chk_hit", 64'(chk_hit), 1);
    chk_addr = 37'h1C0;
    cyc(1, 37'h240, 0, 0);
    cyc(1, 37'h1C0, 0, 0);
    chk("t2_count", 64'(count), 4);
    chk("t2_ovf", 64'(ovf_err), 1);
    chk("t2_stall", 64'(ins_stall), 1);
    chk("t2_chk_1c0", 64'(chk_hit), 0);
    cyc(1, 37'h280, 1, 0);
    chk("t3_rejected", 64'(count), 3);
    cyc(1, 37'h280, 0, 0);
    chk("t3_accepted", 64'(count), 4);
    repeat (4) cyc(0, '0, 1, 0);
    chk("t3_drained", 64'(count), 0);
    p0 = n_pop;
    cyc(1, 37'h200, 0, 0);
    cyc(1, 37'h200, 0, 0);
    chk("t4_coalesce", 64'(count), 1);
    repeat (3) cyc(0, '0, 1, 0);
    chk("t4_pops", 64'(n_pop - p0), 1);
    do_rst();
    cyc(1, 37'h300, 0, 0);
    cyc(1, 37'h340, 0, 0);
    cyc(1, 37'h380, 0, 0);
    pulses = 0;
    p0     = n_pop;
    cyc(0, '0, 1, 1);
    repeat (4) cyc(1, 37'h3C0, 1, 0);
    cyc(0, '0, 1, 0);
    chk("t5_pulses", 64'(pulses), 1);
    chk("t5_pops", 64'(n_pop - p0), 3);
    chk("t5_count", 64'(count), 0);
    chk("t5_run", 64'(ins_stall), 0);
    cyc(0, '0, 0, 1);
    chk("t5e_flush_stall", 64'(ins_stall), 1);
    cyc(0, '0, 0, 1);
    chk("t5e_done", 64'(flush_done), 1);
    cyc(0, '0, 0, 0);
    chk("t5e_done_clr", 64'(flush_done), 0);
    p0 = n_pop;
    cyc(1, 37'h400, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(1, AW'(37'h400 + i * 37'h40), 1, 0);
    repeat (2) cyc(0, '0, 1, 0);
    chk("t6_count", 64'(count), 0);
    chk("t6_pops", 64'(n_pop - p0), 9);
    cyc(1, 37'h500, 0, 0);
    cyc(1, 37'h540, 0, 0);
    cyc(1, 37'h580, 0, 0);
    pulses = 0;
    cyc(0, '0, 0, 1);
    repeat (2) cyc(0, '0, 0, 0);
    chk("t6_in_flush", 64'(ins_stall), 1);
    rst = 1'b1;
    cyc(0, '0, 0, 0);
    rst = 1'b0;
    repeat (4) cyc(0, '0, 0, 0);
    chk("t6_rst_count", 64'(count), 0);
    chk("t6_rst_valid", 64'(out_valid), 0);
    chk("t6_rst_pulses", 64'(pulses), 0);
    chk("t6_rst_stall", 64'(ins_stall), 0);
    chk("never_1c0", 64'(seen_1c0), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
